gb_port_arbiter: RTL and testbench
==================================

GB_PORT_ARBITER -- requirements
Module: gb_port_arbiter

Interface
REQ-001 Parameter RD_LATENCY, default 1, cycles from gb_rd_en to valid gb_rd_data; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_i  input  2  per-requester access request (index 0, 1).
REQ-005 we_i  input  2  per-requester write select; 1 = write, 0 = read.
REQ-006 lock_i  input  2  per-requester hold-priority request.
REQ-007 addr_i  input  2x32  per-requester byte address.
REQ-008 wdata_i  input  2x64  per-requester write data.
REQ-009 strb_i  input  2x8  per-requester byte strobes.
REQ-010 gnt_o  output  2  one-hot-or-zero grant, same cycle as accepted request.
REQ-011 rvalid_o  output  2  per-requester read-data valid pulse.
REQ-012 rdata_o  output  64  read data, shared; qualified by rvalid_o.
REQ-013 gb_rd_en  output  1  global-buffer read enable.
REQ-014 gb_rd_addr  output  32  global-buffer read address.
REQ-015 gb_rd_data  input  64  global-buffer read data.
REQ-016 gb_wr_addr  output  32  global-buffer write address.
REQ-017 gb_wr_data  output  64  global-buffer write data.
REQ-018 gb_wr_strb  output  8  global-buffer write strobes; all-zero = no write.

Function
REQ-019 At most one gnt_o bit high per cycle; gnt_o is combinational from req_i and registered state, zero latency.
REQ-020 Single requester -> granted that cycle; none -> gnt_o=0, gb_rd_en=0, gb_wr_strb=0, all address/data outputs 0.
REQ-021 Both requesting, no lock active -> grant the requester not granted most recently (round-robin); pointer updates only on a grant.
REQ-022 Lock: if the requester granted last cycle had lock_i=1 then, it has absolute priority this cycle; lock ends the first cycle its req or lock drops.
REQ-023 Granted write -> gb_wr_addr/gb_wr_data/gb_wr_strb = requester's addr/wdata/strb same cycle; gb_rd_en=0; strb=0 write granted but is a no-op.
REQ-024 Granted read -> gb_rd_en=1, gb_rd_addr=addr same cycle; gb_wr_strb=0.
REQ-025 Read issued in cycle T -> rvalid_o[owner]=1 for exactly cycle T+RD_LATENCY, rdata_o=gb_rd_data that cycle; otherwise rvalid_o=0, rdata_o=0.
REQ-026 Back-to-back reads every cycle, mixed owners, fully pipelined; no stall, no reordering.
REQ-027 Addresses passed unmodified; no alignment checking.

Reset
REQ-028 During reset: gnt_o=0, rvalid_o=0, rdata_o=0, gb_rd_en=0, gb_wr_strb=0, all address/data outputs 0.
REQ-029 Reset clears the round-robin pointer (requester 0 wins first tie), lock state, and all in-flight read tags; reads issued before reset never produce rvalid_o.
REQ-030 First grant possible in the first cycle after reset deasserts.

Structure
REQ-031 Package gb_arb_pkg holds NREQ=2, ADDR_W=32, DATA_W=64, STRB_W=8, and a request struct typedef (we, lock, addr, wdata, strb).
REQ-032 Sub-module gb_rd_tag_pipe: RD_LATENCY-deep shift register of {valid, owner}, async-reset to zero.

Verification
REQ-033 Req0 read addr 0x100 alone, RD_LATENCY=1 -> gnt_o=01, gb_rd_en=1 same cycle; next cycle rvalid_o=01, rdata_o=gb_rd_data.
REQ-034 Both requesting reads continuously for 4 cycles after reset -> grants 0,1,0,1; rvalid_o sequence 01,10,01,10 delayed RD_LATENCY.
REQ-035 Req0 write with lock_i=1 for 3 cycles while req1 requests -> gnt_o=01 three cycles, then 10.
REQ-036 Req1 write strb=0x0F, wdata=0x1122334455667788 -> gb_wr_strb=0x0F, gb_wr_data matches, gb_rd_en=0.
REQ-037 RD_LATENCY=3, read issued, reset asserted next cycle -> no rvalid_o pulse after reset releases.
REQ-038 Idle cycle (req_i=00) -> all outputs 0, round-robin pointer unchanged.

Source files
------------

// File: rtl/gb_arb_pkg.sv
// Shared widths, request payload and helpers for the two-port global-buffer arbiter.
package gb_arb_pkg;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    function automatic logic [NREQ-1:0] idx2oh(input logic idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/gb_rd_tag_pipe.sv
// Delay line of {valid, owner} tags that marks when a read's data returns.
module gb_rd_tag_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] owner_q, owner_d;

    always_comb begin
        valid_d    = '0;
        owner_d    = '0;
        valid_d[0] = in_valid;
        owner_d[0] = in_owner;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            owner_d[i] = owner_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/gb_port_arbiter.sv
// Two-requester round-robin arbiter with lock onto a single global-buffer port;
// grants and buffer commands are same-cycle, read returns are tracked by tag.
module gb_port_arbiter
    import gb_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          we_i,
    input  logic [NREQ-1:0]          lock_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    input  logic [NREQ*DATA_W-1:0]   wdata_i,
    input  logic [NREQ*STRB_W-1:0]   strb_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     gb_rd_en,
    output logic [ADDR_W-1:0]        gb_rd_addr,
    input  logic [DATA_W-1:0]        gb_rd_data,
    output logic [ADDR_W-1:0]        gb_wr_addr,
    output logic [DATA_W-1:0]        gb_wr_data,
    output logic [STRB_W-1:0]        gb_wr_strb
);

    if (RD_LATENCY == 0 || RD_LATENCY > 4) begin : g_bad_latency
        $error("gb_port_arbiter: RD_LATENCY must be 1..4");
    end

    req_t req [NREQ];
    req_t sel;

    logic rr_last_q, rr_last_d;
    logic lock_q, lock_d;
    logic lock_own_q, lock_own_d;

    logic grant_vld, grant_idx, locked;
    logic is_rd, is_wr;
    logic tag_vld, tag_own;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req[i].we    = we_i[i];
            req[i].lock  = lock_i[i];
            req[i].addr  = addr_i[i*ADDR_W +: ADDR_W];
            req[i].wdata = wdata_i[i*DATA_W +: DATA_W];
            req[i].strb  = strb_i[i*STRB_W +: STRB_W];
        end
    end

    // Lock holds only while the last grantee keeps both req and lock high.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        locked    = lock_q && req_i[lock_own_q] && lock_i[lock_own_q];
        if (reset) begin
            grant_vld = 1'b0;
        end else if (locked) begin
            grant_vld = 1'b1;
            grant_idx = lock_own_q;
        end else if (&req_i) begin
            grant_vld = 1'b1;
            grant_idx = ~rr_last_q;
        end else if (req_i[0]) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
        end else if (req_i[1]) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
        end
    end

    always_comb begin
        sel        = req[grant_idx];
        is_rd      = grant_vld && !sel.we;
        is_wr      = grant_vld && sel.we;
        gnt_o      = grant_vld ? idx2oh(grant_idx) : '0;
        gb_rd_en   = is_rd;
        gb_rd_addr = is_rd ? sel.addr  : '0;
        gb_wr_addr = is_wr ? sel.addr  : '0;
        gb_wr_data = is_wr ? sel.wdata : '0;
        gb_wr_strb = is_wr ? sel.strb  : '0;
    end

    always_comb begin
        rr_last_d  = grant_vld ? grant_idx : rr_last_q;
        lock_d     = grant_vld && sel.lock;
        lock_own_d = grant_vld ? grant_idx : lock_own_q;
    end

    // rr_last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q  <= 1'b1;
            lock_q     <= 1'b0;
            lock_own_q <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            lock_q     <= lock_d;
            lock_own_q <= lock_own_d;
        end
    end

    gb_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (is_rd),
        .in_owner  (grant_idx),
        .out_valid (tag_vld),
        .out_owner (tag_own)
    );

    always_comb begin
        rvalid_o = (tag_vld && !reset) ? idx2oh(tag_own) : '0;
        rdata_o  = (tag_vld && !reset) ? gb_rd_data : '0;
    end

endmodule

// File: tb/tb_gb_port_arbiter.sv
// Directed bench for gb_port_arbiter; one instance at RD_LATENCY=1, one at 3, sharing stimulus.
module tb_gb_port_arbiter;

    logic         clk;
    logic         reset;
    logic [1:0]   req_i, we_i, lock_i;
    logic [63:0]  addr_i;
    logic [127:0] wdata_i;
    logic [15:0]  strb_i;
    logic [63:0]  gb_rd_data;

    logic [1:0]   gnt1, rvalid1, gnt3, rvalid3;
    logic [63:0]  rdata1, rdata3, wr_data1, wr_data3;
    logic         rd_en1, rd_en3;
    logic [31:0]  rd_addr1, rd_addr3, wr_addr1, wr_addr3;
    logic [7:0]   wr_strb1, wr_strb3;

    int total;
    int bad;
    logic [1:0]  eg, e1, e3;
    logic [63:0] dv;

    gb_port_arbiter #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i),
        .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1),
        .gb_rd_en(rd_en1), .gb_rd_addr(rd_addr1), .gb_rd_data(gb_rd_data),
        .gb_wr_addr(wr_addr1), .gb_wr_data(wr_data1), .gb_wr_strb(wr_strb1)
    );

    gb_port_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .strb_i(strb_i),
        .gnt_o(gnt3), .rvalid_o(rvalid3), .rdata_o(rdata3),
        .gb_rd_en(rd_en3), .gb_rd_addr(rd_addr3), .gb_rd_data(gb_rd_data),
        .gb_wr_addr(wr_addr3), .gb_wr_data(wr_data3), .gb_wr_strb(wr_strb3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_i   = '0;
        we_i    = '0;
        lock_i  = '0;
        addr_i  = '0;
        wdata_i = '0;
        strb_i  = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic l, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        req_i[i]            = 1'b1;
        we_i[i]             = w;
        lock_i[i]           = l;
        addr_i[i*32 +: 32]  = a;
        wdata_i[i*64 +: 64] = d;
        strb_i[i*8 +: 8]    = s;
    endtask

    task automatic chk_quiet1(input string tag);
        chk({tag, "_gnt"},  64'(gnt1), 64'h0);
        chk({tag, "_rd"},   64'({rd_en1, rd_addr1}), 64'h0);
        chk({tag, "_wr"},   64'({wr_strb1, wr_addr1}), 64'h0);
        chk({tag, "_wdat"}, wr_data1, 64'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        gb_rd_data = 64'hFFFF_0000_FFFF_0000;

        // Reset gating with live requests
        set_req(0, 1'b0, 1'b0, 32'h100, 64'h0, 8'h0);
        set_req(1, 1'b1, 1'b0, 32'h104, 64'h77, 8'hFF);
        tick();
        #2;
        chk_quiet1("rst");
        chk("rst_rv1",  64'(rvalid1), 64'h0);
        chk("rst_rd1",  rdata1, 64'h0);
        chk("rst_gnt3", 64'(gnt3), 64'h0);
        tick();
        reset = 1'b0;

        // Single read from req0, addr 0x100
        idle();
        set_req(0, 1'b0, 1'b0, 32'h100, 64'h0, 8'h0);
        gb_rd_data = 64'hDEAD_BEEF_0000_0001;
        #2;
        chk("a_gnt",    64'(gnt1), 64'h1);
        chk("a_rden",   64'(rd_en1), 64'h1);
        chk("a_raddr",  64'(rd_addr1), 64'h100);
        chk("a_wstrb",  64'(wr_strb1), 64'h0);
        chk("a_rv1_0",  64'(rvalid1), 64'h0);
        tick();
        idle();
        gb_rd_data = 64'hA5A5_0000_1111_2222;
        #2;
        chk("a_rv1",    64'(rvalid1), 64'h1);
        chk("a_rdata1", rdata1, 64'hA5A5_0000_1111_2222);
        chk("a_rv3_1",  64'(rvalid3), 64'h0);
        tick();
        gb_rd_data = 64'h0BAD_0BAD_0BAD_0BAD;
        #2;
        chk_quiet1("a_idle");
        chk("a_rv1_2",  64'(rvalid1), 64'h0);
        chk("a_rdat1_2", rdata1, 64'h0);
        chk("a_rv3_2",  64'(rvalid3), 64'h0);
        tick();
        gb_rd_data = 64'h3333_4444_5555_6666;
        #2;
        chk("a_rv3",    64'(rvalid3), 64'h1);
        chk("a_rdata3", rdata3, 64'h3333_4444_5555_6666);
        tick();

        // Fresh reset, then both requesters reading for 4 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k < 4) begin
                set_req(0, 1'b0, 1'b0, 32'h200, 64'h0, 8'h0);
                set_req(1, 1'b0, 1'b0, 32'h300, 64'h0, 8'h0);
            end
            dv = 64'h1000 + 64'(k);
            gb_rd_data = dv;
            eg = (k < 4) ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            e1 = (k >= 1 && k <= 4) ? (((k - 1) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            e3 = (k >= 3 && k <= 6) ? (((k - 3) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
            #2;
            chk($sformatf("b_gnt%0d", k),   64'(gnt1), 64'(eg));
            chk($sformatf("b_raddr%0d", k), 64'(rd_addr1),
                (k < 4) ? ((k % 2 == 1) ? 64'h300 : 64'h200) : 64'h0);
            chk($sformatf("b_rv1_%0d", k),  64'(rvalid1), 64'(e1));
            chk($sformatf("b_rd1_%0d", k),  rdata1, (e1 != 2'b00) ? dv : 64'h0);
            chk($sformatf("b_rv3_%0d", k),  64'(rvalid3), 64'(e3));
            chk($sformatf("b_rd3_%0d", k),  rdata3, (e3 != 2'b00) ? dv : 64'h0);
            tick();
        end

        // Lock: req0 locked write holds the port for 3 cycles against req1
        for (int k = 0; k < 3; k++) begin
            idle();
            set_req(0, 1'b1, 1'b1, 32'h400, 64'hCAFE_0000_0000_0001, 8'hFF);
            set_req(1, 1'b0, 1'b0, 32'h500, 64'h0, 8'h0);
            #2;
            chk($sformatf("c_gnt%0d", k),   64'(gnt1), 64'h1);
            chk($sformatf("c_wstrb%0d", k), 64'(wr_strb1), 64'hFF);
            chk($sformatf("c_waddr%0d", k), 64'(wr_addr1), 64'h400);
            chk($sformatf("c_rden%0d", k),  64'(rd_en1), 64'h0);
            tick();
        end
        idle();
        set_req(1, 1'b0, 1'b0, 32'h500, 64'h0, 8'h0);
        #2;
        chk("c_gnt3",   64'(gnt1), 64'h2);
        chk("c_rden3",  64'(rd_en1), 64'h1);
        chk("c_raddr3", 64'(rd_addr1), 64'h500);
        chk("c_wstrb3", 64'(wr_strb1), 64'h0);
        tick();

        // req1 partial-strobe write
        idle();
        set_req(1, 1'b1, 1'b0, 32'h600, 64'h1122_3344_5566_7788, 8'h0F);
        #2;
        chk("d_gnt",   64'(gnt1), 64'h2);
        chk("d_wstrb", 64'(wr_strb1), 64'h0F);
        chk("d_wdata", wr_data1, 64'h1122_3344_5566_7788);
        chk("d_waddr", 64'(wr_addr1), 64'h600);
        chk("d_rden",  64'(rd_en1), 64'h0);
        tick();

        // Zero-strobe write is still granted
        idle();
        set_req(0, 1'b1, 1'b0, 32'h700, 64'h55, 8'h00);
        #2;
        chk("d0_gnt",   64'(gnt1), 64'h1);
        chk("d0_wstrb", 64'(wr_strb1), 64'h0);
        chk("d0_waddr", 64'(wr_addr1), 64'h700);
        chk("d0_rden",  64'(rd_en1), 64'h0);
        tick();

        // Idle keeps the pointer: last grant was req0, so req1 wins the next tie
        idle();
        #2;
        chk_quiet1("e_idle");
        tick();
        set_req(0, 1'b0, 1'b0, 32'h800, 64'h0, 8'h0);
        set_req(1, 1'b0, 1'b0, 32'h900, 64'h0, 8'h0);
        #2;
        chk("e_gnt",   64'(gnt1), 64'h2);
        chk("e_raddr", 64'(rd_addr1), 64'h900);
        tick();

        // Reset right after a read: the in-flight tag must never surface
        reset = 1'b1;
        #2;
        chk("f_gnt_r0", 64'(gnt1), 64'h0);
        chk("f_rv1_r0", 64'(rvalid1), 64'h0);
        chk("f_rv3_r0", 64'(rvalid3), 64'h0);
        chk("f_rden_r0", 64'(rd_en1), 64'h0);
        tick();
        #2;
        chk("f_rv3_r1", 64'(rvalid3), 64'h0);
        tick();
        reset = 1'b0;
        gb_rd_data = 64'h9999_8888_7777_6666;
        #2;
        chk("f_gnt_first", 64'(gnt1), 64'h1);
        chk("f_rv3_0",     64'(rvalid3), 64'h0);
        chk("f_rd3_0",     rdata3, 64'h0);
        tick();
        idle();
        #2;
        chk("f_rv1_new", 64'(rvalid1), 64'h1);
        chk("f_rv3_1",   64'(rvalid3), 64'h0);
        tick();
        #2;
        chk("f_rv3_2",   64'(rvalid3), 64'h0);
        tick();
        #2;
        chk("f_rv3_new", 64'(rvalid3), 64'h1);
        chk("f_rd3_new", rdata3, 64'h9999_8888_7777_6666);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
